// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: packet-locked round-robin N:1 valid/ready arbiter with a registered output stage.
// Define HANDSHAKE_ARB_MAXBURST_EN to release the grant after MAX_BEATS beats even without s_last.
module handshake_rr_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned SRC_BITS = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           s_valid,
  output logic [NUM_SRC-1:0]           s_ready,
  input  logic [NUM_SRC*DATA_BITS-1:0] s_data,
  input  logic [NUM_SRC-1:0]           s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_BITS-1:0]         m_data,
  output logic                         m_last,
  output logic [SRC_BITS-1:0]          m_src,
  output logic                         busy
);

  localparam int unsigned CAND_BITS = SRC_BITS + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SRC_BITS-1:0]    ptr_q, ptr_d;
  logic [SRC_BITS-1:0]    grant_q, grant_d;
  logic                   m_valid_q, m_valid_d;
  logic [DATA_BITS-1:0]   m_data_q, m_data_d;
  logic                   m_last_q, m_last_d;
  logic [SRC_BITS-1:0]    m_src_q, m_src_d;
  logic                   busy_q, busy_d;

  logic                   rr_found_c;
  logic [SRC_BITS-1:0]    rr_pick_c;
  logic [CAND_BITS-1:0]   cand_c;
  logic                   sel_valid_c;
  logic                   sel_last_c;
  logic [DATA_BITS-1:0]   sel_data_c;
  logic                   out_free_c;
  logic                   take_c;
  logic                   cap_hit_c;
  logic [SRC_BITS-1:0]    next_ptr_c;

  // Round-robin scan starting at ptr, wrapping past NUM_SRC-1.
  always_comb begin
    rr_found_c = 1'b0;
    rr_pick_c  = '0;
    cand_c     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand_c = {1'b0, ptr_q} + CAND_BITS'(i);
      if (cand_c >= CAND_BITS'(NUM_SRC)) begin
        cand_c = cand_c - CAND_BITS'(NUM_SRC);
      end
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if (!rr_found_c && s_valid[j] && (cand_c == CAND_BITS'(j))) begin
          rr_found_c = 1'b1;
          rr_pick_c  = SRC_BITS'(j);
        end
      end
    end
  end

  // Granted-source mux and ready steering.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_last_c  = 1'b0;
    sel_data_c  = '0;
    s_ready     = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (grant_q == SRC_BITS'(j)) begin
        sel_valid_c = s_valid[j];
        sel_last_c  = s_last[j];
        sel_data_c  = s_data[j*DATA_BITS +: DATA_BITS];
        s_ready[j]  = (state_q == GRANT) && out_free_c;
      end
    end
  end

  assign out_free_c = !m_valid_q || m_ready;
  assign take_c     = (state_q == GRANT) && sel_valid_c && out_free_c;
  assign next_ptr_c = (grant_q == SRC_BITS'(NUM_SRC - 1)) ? '0 : grant_q + SRC_BITS'(1);

`ifdef HANDSHAKE_ARB_MAXBURST_EN
  localparam int unsigned CNT_BITS = $clog2(MAX_BEATS + 1);

  logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;

  // Beats accepted in the current grant; cleared while idle so each grant starts at zero.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      beat_cnt_d = '0;
    end else if (take_c) begin
      beat_cnt_d = beat_cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign cap_hit_c = take_c && (beat_cnt_q == CNT_BITS'(MAX_BEATS - 1));
`else
  // Burst cap compiled out: grant is held until s_last is accepted.
  assign cap_hit_c = 1'b0 && (MAX_BEATS > 0);
`endif

  // Next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_src_d   = m_src_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rr_found_c) begin
          grant_d = rr_pick_c;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (take_c) begin
          m_valid_d = 1'b1;
          m_data_d  = sel_data_c;
          m_last_d  = sel_last_c;
          m_src_d   = grant_q;
          if (sel_last_c || cap_hit_c) begin
            ptr_d   = next_ptr_c;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_src_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_src_q   <= m_src_d;
      busy_q    <= busy_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_src   = m_src_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter: source BFMs from per-source beat tables, output scoreboard queue.
module tb_handshake_rr_arbiter;

  localparam int unsigned NUM_SRC   = 4;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned SRC_BITS  = 2;

  typedef struct packed {
    logic [SRC_BITS-1:0]  src;
    logic [DATA_BITS-1:0] data;
    logic                 last;
    logic [7:0]           gap;   // cycles since previous output beat; 0 = not checked
  } beat_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_SRC-1:0]           s_valid;
  logic [NUM_SRC-1:0]           s_ready;
  logic [NUM_SRC*DATA_BITS-1:0] s_data;
  logic [NUM_SRC-1:0]           s_last;
  logic                         m_valid;
  logic                         m_ready;
  logic [DATA_BITS-1:0]         m_data;
  logic                         m_last;
  logic [SRC_BITS-1:0]          m_src;
  logic                         busy;

  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    last_out    = 0;
  beat_t exp_q[$];

  logic [8:0]         mem [NUM_SRC][16];
  int                 rd  [NUM_SRC];
  int                 wr  [NUM_SRC];
  logic [NUM_SRC-1:0] en;

  always #5 clk = ~clk;

  handshake_rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .DATA_BITS(DATA_BITS),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last),
    .m_src  (m_src),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NUM_SRC; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    en = '1;
  endtask

  task automatic load(input int s, input logic [7:0] d, input logic l);
    mem[s][wr[s]] = {l, d};
    wr[s]++;
  endtask

  task automatic expect_beat(input int s, input logic [7:0] d, input logic l, input int g);
    beat_t b;
    b.src  = SRC_BITS'(s);
    b.data = d;
    b.last = l;
    b.gap  = 8'(g);
    exp_q.push_back(b);
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (en[i] && rd[i] < wr[i]) begin
        s_valid[i]                        = 1'b1;
        s_data[i*DATA_BITS +: DATA_BITS]  = mem[i][rd[i]][7:0];
        s_last[i]                         = mem[i][rd[i]][8];
      end else begin
        s_valid[i]                        = 1'b0;
        s_data[i*DATA_BITS +: DATA_BITS]  = '0;
        s_last[i]                         = 1'b0;
      end
    end
  endtask

  // One clock: drive sources, score any output transfer, advance accepted sources.
  task automatic tick();
    beat_t              e;
    logic [NUM_SRC-1:0] acc;
    drive_srcs();
    #1;
    acc = s_valid & s_ready;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL extra_beat: got src %0d data %h, expected no beat", m_src, m_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_src",  32'(m_src),  32'(e.src));
        chk("m_data", 32'(m_data), 32'(e.data));
        chk("m_last", 32'(m_last), 32'(e.last));
        if (e.gap != 8'd0) chk("beat_gap", 32'(cyc - last_out), 32'(e.gap));
      end
      last_out = cyc;
    end
    @(posedge clk);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (acc[i]) rd[i]++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_srcs();
    drive_srcs();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 50000");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    m_ready = 1'b0;
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    clear_srcs();
    @(negedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    chk("rst_m_last",  32'(m_last),  32'd0);
    chk("rst_m_src",   32'(m_src),   32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    rst = 1'b1;

    // Async reset mid-packet; pointer must return to 0
    load(0, 8'h11, 1'b1);
    expect_beat(0, 8'h11, 1'b1, 0);
    m_ready = 1'b1;
    drain("t1_pre", 20);
    load(1, 8'h21, 1'b0); load(1, 8'h22, 1'b0); load(1, 8'h23, 1'b1);
    m_ready = 1'b0;
    tick(); tick();
    chk("t1_mid_m_valid", 32'(m_valid), 32'd1);
    chk("t1_mid_busy",    32'(busy),    32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t1_async_m_valid", 32'(m_valid), 32'd0);
    chk("t1_async_s_ready", 32'(s_ready), 32'd0);
    chk("t1_async_busy",    32'(busy),    32'd0);
    clear_srcs();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    load(0, 8'h31, 1'b1); load(1, 8'h41, 1'b1);
    expect_beat(0, 8'h31, 1'b1, 0);
    expect_beat(1, 8'h41, 1'b1, 0);
    m_ready = 1'b1;
    drain("t1_post", 20);

    // Two-beat packet at full rate, then a one-cycle arbitration gap before the next packet
    clear_srcs();
    load(0, 8'hA5, 1'b0); load(0, 8'hC4, 1'b1); load(0, 8'h5A, 1'b1);
    expect_beat(0, 8'hA5, 1'b0, 0);
    expect_beat(0, 8'hC4, 1'b1, 1);
    expect_beat(0, 8'h5A, 1'b1, 2);
    drain("t2", 20);

    // All sources requesting single-beat packets: order 0,1,2,3,0
    do_reset();
    load(0, 8'h00, 1'b1); load(0, 8'h04, 1'b1);
    load(1, 8'h01, 1'b1); load(2, 8'h02, 1'b1); load(3, 8'h03, 1'b1);
    expect_beat(0, 8'h00, 1'b1, 0);
    expect_beat(1, 8'h01, 1'b1, 2);
    expect_beat(2, 8'h02, 1'b1, 2);
    expect_beat(3, 8'h03, 1'b1, 2);
    expect_beat(0, 8'h04, 1'b1, 2);
    m_ready = 1'b1;
    drain("t3", 30);

    // Output stall in the middle of a 3-beat packet
    clear_srcs();
    load(2, 8'hB0, 1'b0); load(2, 8'hB1, 1'b0); load(2, 8'hB2, 1'b1);
    expect_beat(2, 8'hB0, 1'b0, 0);
    expect_beat(2, 8'hB1, 1'b0, 3);
    expect_beat(2, 8'hB2, 1'b1, 1);
    m_ready = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      m_ready = 1'b0;
      #1;
      chk("t4_stall_m_valid", 32'(m_valid), 32'd1);
      chk("t4_stall_m_data",  32'(m_data),  32'hB1);
      chk("t4_stall_m_src",   32'(m_src),   32'd2);
      chk("t4_stall_s_ready", 32'(s_ready), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    tick(); tick();
    drain("t4", 10);

    // Granted source pauses mid-packet; a waiting source is not granted meanwhile
    do_reset();
    load(1, 8'h51, 1'b0); load(1, 8'h52, 1'b0); load(1, 8'h53, 1'b1);
    load(3, 8'h71, 1'b1);
    expect_beat(1, 8'h51, 1'b0, 0);
    expect_beat(1, 8'h52, 1'b0, 6);
    expect_beat(1, 8'h53, 1'b1, 1);
    expect_beat(3, 8'h71, 1'b1, 2);
    m_ready = 1'b1;
    tick(); tick();
    en[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_srcs();
      #1;
      chk("t5_src3_ready", 32'(s_ready[3]), 32'd0);
      chk("t5_busy",       32'(busy),       32'd1);
      tick();
    end
    en[1] = 1'b1;
    drain("t5", 40);

    // Long packet from src0 with a competing single beat on src1
    clear_srcs();
    for (int k = 0; k < 10; k++) load(0, 8'(8'hE0 + k), (k == 9));
    load(1, 8'hF1, 1'b1);
`ifdef HANDSHAKE_ARB_MAXBURST_EN
    for (int k = 0; k < 4; k++)  expect_beat(0, 8'(8'hE0 + k), 1'b0, 0);
    expect_beat(1, 8'hF1, 1'b1, 0);
    for (int k = 4; k < 10; k++) expect_beat(0, 8'(8'hE0 + k), (k == 9), 0);
`else
    for (int k = 0; k < 10; k++) expect_beat(0, 8'(8'hE0 + k), (k == 9), 0);
    expect_beat(1, 8'hF1, 1'b1, 0);
`endif
    m_ready = 1'b1;
    drain("t6", 80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
